// File: rtl/waveform_pkg.sv
// Shared types for the waveform trigger arbiter.
// FSM state encoding and trigger pulse length.
package waveform_pkg;
  typedef enum logic [1:0] {IDLE, TRIG, PLAY, GAP} arb_state_t;
  localparam int TRIG_CYCLES = 2;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr.
// Returns one-hot grant, its index and an any-request flag.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index,
  output logic          any
);
  int idx;

  always_comb begin
    grant = '0;
    index = '0;
    any   = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        index      = IW'(idx);
      end
    end
  end
endmodule

// File: rtl/waveform_trigger_arbiter.sv
// Shares one PWM waveform generator among N_REQ requesters.
// Round-robin accept, 2-cycle trigger, internally timed burst, forced gap.
module waveform_trigger_arbiter
  import waveform_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int PWM_RESOLUTION = 16,
  parameter int D              = 8,
  parameter int GAP_CYCLES     = 4,
  parameter int IW             = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*D-1:0] req_duration,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   done,
  output logic               gen_trigger,
  output logic [D-1:0]       gen_duration,
  output logic               busy,
  output logic [IW-1:0]      grant_id
);
  localparam int CW = D + PWM_RESOLUTION;
  localparam int PW = $clog2(GAP_CYCLES + TRIG_CYCLES);

  arb_state_t       state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    win_q, win_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic [N_REQ-1:0] ready_q, ready_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic             trig_q, trig_d;
  logic [D-1:0]     dur_q, dur_d;
  logic [IW-1:0]    grant_q, grant_d;
  logic             busy_q, busy_d;

  logic [N_REQ-1:0] arb_grant;
  logic [IW-1:0]    arb_idx;
  logic             arb_any;
  logic [D-1:0]     sel_dur;

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .index (arb_idx),
    .any   (arb_any)
  );

  always_comb begin
    sel_dur = '0;
    for (int i = 0; i < N_REQ; i++)
      if (arb_idx == IW'(i))
        sel_dur = req_duration[i*D +: D];
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    phase_d = phase_q;
    ready_d = '0;
    done_d  = '0;
    trig_d  = 1'b0;
    dur_d   = dur_q;
    grant_d = grant_q;
    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          ready_d = arb_grant;
          dur_d   = sel_dur;
          grant_d = arb_idx;
          ptr_d   = (arb_idx == IW'(N_REQ-1)) ? '0 : arb_idx + 1'b1;
          win_d   = (CW'(sel_dur) << PWM_RESOLUTION) - 1'b1;
          // Zero-length burst skips the generator entirely
          if (sel_dur == '0) begin
            state_d = GAP;
            done_d  = arb_grant;
            phase_d = PW'(GAP_CYCLES - 1);
          end else begin
            state_d = TRIG;
            trig_d  = 1'b1;
            phase_d = PW'(TRIG_CYCLES - 1);
          end
        end
      end
      TRIG, PLAY: begin
        if (win_q == '0) begin
          state_d = GAP;
          done_d  = {{(N_REQ-1){1'b0}}, 1'b1} << grant_q;
          phase_d = PW'(GAP_CYCLES - 1);
        end else begin
          win_d = win_q - 1'b1;
          if (state_q == TRIG) begin
            if (phase_q == '0) begin
              state_d = PLAY;
            end else begin
              phase_d = phase_q - 1'b1;
              trig_d  = 1'b1;
            end
          end
        end
      end
      GAP: begin
        if (phase_q == '0) state_d = IDLE;
        else               phase_d = phase_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      phase_q <= '0;
      ready_q <= '0;
      done_q  <= '0;
      trig_q  <= 1'b0;
      dur_q   <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      phase_q <= phase_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      trig_q  <= trig_d;
      dur_q   <= dur_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
    end
  end

  assign req_ready    = ready_q;
  assign done         = done_q;
  assign gen_trigger  = trig_q;
  assign gen_duration = dur_q;
  assign busy         = busy_q;
  assign grant_id     = grant_q;
endmodule

// File: tb/tb_waveform_trigger_arbiter.sv
// Bench for waveform_trigger_arbiter: directed table, corner sequences,
// and random traffic against a burst-level timing model.
module tb_waveform_trigger_arbiter;
  localparam int N   = 4;
  localparam int PR  = 4;
  localparam int DW  = 8;
  localparam int GAP = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N*DW-1:0] req_duration = '0;
  logic [N-1:0]  req_ready;
  logic [N-1:0]  done;
  logic          gen_trigger;
  logic [DW-1:0] gen_duration;
  logic          busy;
  logic [1:0]    grant_id;

  int checks = 0;
  int errors = 0;

  waveform_trigger_arbiter #(
    .N_REQ(N), .PWM_RESOLUTION(PR), .D(DW), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_duration(req_duration),
    .req_ready(req_ready), .done(done),
    .gen_trigger(gen_trigger), .gen_duration(gen_duration),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, act, exp);
    end
  endtask

  // Burst-level model: each accepted burst is an interval of cycles
  int mcyc   = 0;
  bit m_has  = 0;
  int m_acc  = 0;
  int m_dur  = 0;
  int m_own  = 0;
  int m_ptr  = 0;
  int m_gdur = 0;
  int m_gid  = 0;

  always @(negedge clk) begin
    int w, er, ed, et, eb, pick;
    w  = m_dur * (1 << PR);
    er = 0; ed = 0; et = 0; eb = 0;
    if (m_has) begin
      if (mcyc == m_acc + 1) er = 1 << m_own;
      if (mcyc == m_acc + w + 1) ed = 1 << m_own;
      if (m_dur != 0 && (mcyc == m_acc + 1 || mcyc == m_acc + 2)) et = 1;
      if (mcyc >= m_acc + 1 && mcyc <= m_acc + w + GAP) eb = 1;
    end
    if (mcyc >= 1) begin
      chk("m_ready", int'(req_ready), er);
      chk("m_done", int'(done), ed);
      chk("m_trig", int'(gen_trigger), et);
      chk("m_busy", int'(busy), eb);
      chk("m_dur", int'(gen_duration), m_gdur);
      chk("m_gid", int'(grant_id), m_gid);
    end
    if (rst) begin
      m_has = 0; m_ptr = 0; m_gdur = 0; m_gid = 0;
    end else if ((!m_has || mcyc > m_acc + w + GAP) && |req_valid) begin
      pick = -1;
      for (int k = 0; k < N; k++)
        if (pick < 0 && req_valid[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
      m_has  = 1;
      m_acc  = mcyc;
      m_own  = pick;
      m_dur  = int'(req_duration[pick*DW +: DW]);
      m_gdur = m_dur;
      m_gid  = pick;
      m_ptr  = (pick + 1) % N;
    end
    mcyc++;
  end

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    rst = 1'b1;
    next_cyc();
    rst = 1'b0;
  endtask

  function automatic int first_idx(input logic [N-1:0] v);
    int r = -1;
    for (int i = N - 1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  typedef struct {
    int idx; int dur;
    int ready_off; int trig_cnt; int done_off; int free_off;
  } vec_t;

  task automatic run_single(input int idx, input int dur, input int limit,
                            output int r_off, output int t_cnt,
                            output int d_off, output int f_off);
    r_off = -1; t_cnt = 0; d_off = -1; f_off = -1;
    req_duration[idx*DW +: DW] = DW'(dur);
    req_valid = '0;
    req_valid[idx] = 1'b1;
    for (int off = 0; off < limit; off++) begin
      @(negedge clk);
      if (req_ready[idx] && r_off < 0) r_off = off;
      if (gen_trigger) t_cnt++;
      if (done[idx] && d_off < 0) d_off = off;
      if (off > 0 && !busy && f_off < 0) f_off = off;
      next_cyc();
      if (r_off >= 0) req_valid[idx] = 1'b0;
    end
  endtask

  initial begin
    vec_t tbl[4];
    int r, t, d, f, n;
    int g[4];
    int gc[4];
    logic [N-1:0] rdy;

    tbl[0] = '{0, 4,   1, 2, 65,   69};
    tbl[1] = '{3, 0,   1, 0, 1,    5};
    tbl[2] = '{1, 1,   1, 2, 17,   21};
    tbl[3] = '{2, 255, 1, 2, 4081, 4085};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_gid", int'(grant_id), 0);
    next_cyc();

    for (int v = 0; v < 4; v++) begin
      do_reset();
      run_single(tbl[v].idx, tbl[v].dur, tbl[v].free_off + 3, r, t, d, f);
      chk("tbl_ready_off", r, tbl[v].ready_off);
      chk("tbl_trig_cnt", t, tbl[v].trig_cnt);
      chk("tbl_done_off", d, tbl[v].done_off);
      chk("tbl_free_off", f, tbl[v].free_off);
    end

    // Contention: all four at once, dur=1
    do_reset();
    req_duration = {8'd1, 8'd1, 8'd1, 8'd1};
    req_valid = 4'hF;
    n = 0;
    for (int i = 0; i < 4; i++) begin g[i] = -1; gc[i] = 0; end
    for (int c = 0; c < 150 && n < 4; c++) begin
      @(negedge clk);
      rdy = req_ready;
      if (|rdy) begin
        chk("cont_onehot", int'($onehot(rdy)), 1);
        g[n] = first_idx(rdy);
        gc[n] = c;
        n++;
      end
      next_cyc();
      req_valid = req_valid & ~rdy;
    end
    chk("cont_count", n, 4);
    for (int i = 0; i < 4; i++) chk("cont_order", g[i], i);
    for (int i = 1; i < 4; i++)
      chk("cont_space", gc[i] - gc[i-1], (1 << PR) + GAP + 1);

    // Fairness: req1 held, req2 raised mid-burst
    do_reset();
    req_duration = {8'd1, 8'd1, 8'd1, 8'd1};
    req_valid = 4'b0010;
    n = 0;
    for (int i = 0; i < 4; i++) g[i] = -1;
    for (int c = 0; c < 120 && n < 3; c++) begin
      @(negedge clk);
      rdy = req_ready;
      if (|rdy) begin g[n] = first_idx(rdy); n++; end
      next_cyc();
      if (c == 5) req_valid[2] = 1'b1;
      if (rdy[2]) req_valid[2] = 1'b0;
    end
    chk("fair_g0", g[0], 1);
    chk("fair_g1", g[1], 2);
    chk("fair_g2", g[2], 1);
    req_valid = '0;

    // Reset during PLAY of a dur=4 burst
    do_reset();
    req_duration = {8'd1, 8'd1, 8'd1, 8'd4};
    req_valid = 4'b0001;
    for (int off = 0; off < 30; off++) begin
      @(negedge clk);
      rdy = req_ready;
      next_cyc();
      if (rdy[0]) req_valid[0] = 1'b0;
    end
    rst = 1'b1;
    next_cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_trig", int'(gen_trigger), 0);
    chk("mid_rst_dur", int'(gen_duration), 0);
    chk("mid_rst_done", int'(done), 0);
    next_cyc();
    n = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (|done) n++;
      next_cyc();
    end
    chk("mid_rst_nodone", n, 0);
    req_valid = 4'b0011;
    r = -1;
    for (int c = 0; c < 10 && r < 0; c++) begin
      @(negedge clk);
      if (|req_ready) r = first_idx(req_ready);
      next_cyc();
    end
    chk("mid_rst_regrant", r, 0);
    req_valid = '0;

    // Random traffic against the model
    rdy = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rdy = req_ready;
      next_cyc();
      rst = ($urandom_range(0, 599) == 0);
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && (rdy[i] || $urandom_range(0, 59) == 0))
          req_valid[i] = 1'b0;
        else if (!req_valid[i] && $urandom_range(0, 5) == 0) begin
          req_duration[i*DW +: DW] = DW'($urandom_range(0, 3));
          req_valid[i] = 1'b1;
        end
      end
    end
    rst = 1'b0;
    req_valid = '0;
    repeat (2) next_cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1);
  end
endmodule
